nervous_shock_monitor: RTL and testbench

- Parametrised successor to the single-pattern nervous shock detector.
- Detects a configurable N-bit pattern, overlaps allowed, in a gated serial nerve-signal bitstream.
- Counts matches per fixed window of valid samples and grades each closed window into a 2-bit abnormality level.
- Escalates to critical after consecutive severe windows and drives a sticky alarm to the healthcare-system alert logic.

---
 rtl/nervous_shock_monitor.sv | 133 +++++++++++++
 tb/tb_nervous_shock_monitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nervous_shock_monitor.sv
// rtl/nervous_shock_monitor.sv - serial pattern matcher with windowed abnormality grading and sticky alarm (optional NSM_GRADE_DECAY_EN)
module nervous_shock_monitor #(
    parameter int                     PATTERN_LEN  = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN      = 4'b1010,
    parameter int                     WINDOW       = 8,
    parameter int                     MILD_TH      = 1,
    parameter int                     SEVERE_TH    = 3,
    parameter int                     CRIT_WINDOWS = 2,
    localparam int                    CNT_W        = $clog2(WINDOW + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic             inputdata,
    input  logic             clear_alarm,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             window_done,
    output logic [1:0]       nervousAbnormality,
    output logic             alarm
);

    localparam int FILL_W = $clog2(PATTERN_LEN);
    localparam int SCNT_W = $clog2(WINDOW);
    localparam int RUN_W  = $clog2(CRIT_WINDOWS + 1);

    localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(PATTERN_LEN - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'(WINDOW - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX    = RUN_W'(CRIT_WINDOWS);
    localparam logic [31:0]       MILD_U     = 32'(MILD_TH);
    localparam logic [31:0]       SEVERE_U   = 32'(SEVERE_TH);

    localparam logic [1:0] GRADE_NORMAL = 2'b00;
    localparam logic [1:0] GRADE_MILD   = 2'b01;
    localparam logic [1:0] GRADE_SEVERE = 2'b10;
    localparam logic [1:0] GRADE_CRIT   = 2'b11;

    // Only the N-1 previous bits are stored; the current input completes the pattern.
    logic [PATTERN_LEN-2:0] hist;
    logic [FILL_W-1:0]      fill;
    logic [SCNT_W-1:0]      scnt;
    logic [RUN_W-1:0]       severe_run;

    logic [PATTERN_LEN-1:0] shifted;
    logic                   hit;
    logic                   closing;
    logic [CNT_W:0]         sum;
    logic [CNT_W-1:0]       total;
    logic [1:0]             raw_class;
    logic [RUN_W-1:0]       run_next;
    logic [1:0]             target;
    logic [1:0]             grade_next;
    logic                   alarm_set;

    // Match detection, window totals and next-grade computation.
    always_comb begin
        shifted = {hist, inputdata};
        hit     = sample_valid && (fill == FILL_LAST) && (shifted == PATTERN);
        closing = sample_valid && (scnt == SCNT_LAST);

        sum   = {1'b0, match_count} + (CNT_W + 1)'(hit);
        total = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

        if (32'(total) >= SEVERE_U) begin
            raw_class = GRADE_SEVERE;
        end else if (32'(total) >= MILD_U) begin
            raw_class = GRADE_MILD;
        end else begin
            raw_class = GRADE_NORMAL;
        end

        if (raw_class == GRADE_SEVERE) begin
            run_next = (severe_run == RUN_MAX) ? severe_run : severe_run + RUN_W'(1);
        end else begin
            run_next = '0;
        end

        target = (run_next >= RUN_MAX) ? GRADE_CRIT : raw_class;

`ifdef NSM_GRADE_DECAY_EN
        // Escalate at once, but step down only one level per closed window.
        if (target >= nervousAbnormality) begin
            grade_next = target;
        end else begin
            grade_next = nervousAbnormality - 2'd1;
        end
`else
        grade_next = target;
`endif

        alarm_set = closing && (grade_next == GRADE_CRIT) && (nervousAbnormality != GRADE_CRIT);
    end

    // Sample history, counters, grade and alarm state.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist               <= '0;
            fill               <= '0;
            scnt               <= '0;
            severe_run         <= '0;
            match_pulse        <= 1'b0;
            match_count        <= '0;
            window_done        <= 1'b0;
            nervousAbnormality <= GRADE_NORMAL;
            alarm              <= 1'b0;
        end else begin
            match_pulse <= hit;
            window_done <= closing;
            if (sample_valid) begin
                hist <= shifted[PATTERN_LEN-2:0];
                if (fill != FILL_LAST) begin
                    fill <= fill + FILL_W'(1);
                end
                if (closing) begin
                    scnt               <= '0;
                    match_count        <= '0;
                    severe_run         <= run_next;
                    nervousAbnormality <= grade_next;
                end else begin
                    scnt        <= scnt + SCNT_W'(1);
                    match_count <= total;
                end
            end
            // A new critical grade beats a simultaneous clear request.
            if (alarm_set) begin
                alarm <= 1'b1;
            end else if (clear_alarm) begin
                alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nervous_shock_monitor.sv
// tb/tb_nervous_shock_monitor.sv - scoreboard bench for nervous_shock_monitor with directed vectors
module tb_nervous_shock_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic       inputdata = 1'b0;
    logic       clear_alarm = 1'b0;
    logic       match_pulse;
    logic [3:0] match_count;
    logic       window_done;
    logic [1:0] nervousAbnormality;
    logic       alarm;

    typedef struct {
        int pulse;
        int done;
        int cnt;
        int grade;
        int alm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic clr_hold = 1'b0;

`ifdef NSM_GRADE_DECAY_EN
    localparam int GC = 2;
    localparam int GD = 1;
`else
    localparam int GC = 1;
    localparam int GD = 0;
`endif

    nervous_shock_monitor dut (
        .clock              (clock),
        .reset              (reset),
        .sample_valid       (sample_valid),
        .inputdata          (inputdata),
        .clear_alarm        (clear_alarm),
        .match_pulse        (match_pulse),
        .match_count        (match_count),
        .window_done        (window_done),
        .nervousAbnormality (nervousAbnormality),
        .alarm              (alarm)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle after the edge, pop the expected response and compare.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("match_pulse", int'(match_pulse), e.pulse);
            chk("window_done", int'(window_done), e.done);
            chk("match_count", int'(match_count), e.cnt);
            chk("grade", int'(nervousAbnormality), e.grade);
            chk("alarm", int'(alarm), e.alm);
        end
    end

    task automatic step(input logic v, input logic d, input logic c, input logic r,
                        input int ep, input int ed, input int ec, input int eg, input int ea);
        exp_t e;
        @(negedge clock);
        sample_valid = v;
        inputdata    = d;
        clear_alarm  = c;
        reset        = r;
        e.pulse = ep; e.done = ed; e.cnt = ec; e.grade = eg; e.alm = ea;
        exp_q.push_back(e);
    endtask

    // Valid sample; clear_alarm follows clr_hold.
    task automatic vs(input logic d, input int ep, input int ed, input int ec, input int eg, input int ea);
        step(1'b1, d, clr_hold, 1'b0, ep, ed, ec, eg, ea);
    endtask

    task automatic idle(input logic c, input int ec, input int eg, input int ea);
        step(1'b0, 1'b0, c, 1'b0, 0, 0, ec, eg, ea);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);

        // Window A: 10101010 -> matches at samples 4,6,8, grade severe
        vs(1, 0, 0, 0, 0, 0); vs(0, 0, 0, 0, 0, 0); vs(1, 0, 0, 0, 0, 0); vs(0, 1, 0, 1, 0, 0);
        vs(1, 0, 0, 1, 0, 0); vs(0, 1, 0, 2, 0, 0); vs(1, 0, 0, 2, 0, 0); vs(0, 1, 1, 0, 2, 0);

        // Window B: same bits, history overlap adds a match at sample 2 -> critical, alarm
        vs(1, 0, 0, 0, 2, 0); vs(0, 1, 0, 1, 2, 0); vs(1, 0, 0, 1, 2, 0); vs(0, 1, 0, 2, 2, 0);
        vs(1, 0, 0, 2, 2, 0); vs(0, 1, 0, 3, 2, 0); vs(1, 0, 0, 3, 2, 0); vs(0, 1, 1, 0, 3, 1);

        // clear_alarm pulse: alarm drops, grade stays critical
        idle(1'b1, 0, 3, 0);

        // Window C: 10100000 -> two matches (one via history) -> mild
        vs(1, 0, 0, 0, 3, 0); vs(0, 1, 0, 1, 3, 0); vs(1, 0, 0, 1, 3, 0); vs(0, 1, 0, 2, 3, 0);
        vs(0, 0, 0, 2, 3, 0); vs(0, 0, 0, 2, 3, 0); vs(0, 0, 0, 2, 3, 0); vs(0, 0, 1, 0, GC, 0);

        // Window D: all zeros -> normal (or one step down with decay)
        for (int i = 0; i < 7; i++) vs(0, 0, 0, 0, GC, 0);
        vs(0, 0, 1, 0, GD, 0);

        // Gated samples 1,0,1,0 with 3 idle cycles between each
        vs(1, 0, 0, 0, GD, 0);
        for (int i = 0; i < 3; i++) idle(1'b0, 0, GD, 0);
        vs(0, 0, 0, 0, GD, 0);
        for (int i = 0; i < 3; i++) idle(1'b0, 0, GD, 0);
        vs(1, 0, 0, 0, GD, 0);
        for (int i = 0; i < 3; i++) idle(1'b0, 0, GD, 0);
        vs(0, 1, 0, 1, GD, 0);
        vs(1, 0, 0, 1, GD, 0);

        // Mid-window reset: everything back to zero
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);

        // Window F: 01010111 -> stale history would match at sample 1; fresh gives one match at 5
        vs(0, 0, 0, 0, 0, 0); vs(1, 0, 0, 0, 0, 0); vs(0, 0, 0, 0, 0, 0); vs(1, 0, 0, 0, 0, 0);
        vs(0, 1, 0, 1, 0, 0); vs(1, 0, 0, 1, 0, 0); vs(1, 0, 0, 1, 0, 0); vs(1, 0, 1, 0, 1, 0);

        // Window G: 01010101 -> three matches -> severe
        vs(0, 0, 0, 0, 1, 0); vs(1, 0, 0, 0, 1, 0); vs(0, 1, 0, 1, 1, 0); vs(1, 0, 0, 1, 1, 0);
        vs(0, 1, 0, 2, 1, 0); vs(1, 0, 0, 2, 1, 0); vs(0, 1, 0, 3, 1, 0); vs(1, 0, 1, 0, 2, 0);

        // Window H with clear_alarm held high: critical reached, set wins over clear
        clr_hold = 1'b1;
        vs(0, 1, 0, 1, 2, 0); vs(1, 0, 0, 1, 2, 0); vs(0, 1, 0, 2, 2, 0); vs(1, 0, 0, 2, 2, 0);
        vs(0, 1, 0, 3, 2, 0); vs(1, 0, 0, 3, 2, 0); vs(0, 1, 0, 4, 2, 0); vs(1, 0, 1, 0, 3, 1);
        idle(1'b1, 0, 3, 0);
        clr_hold = 1'b0;
        idle(1'b0, 0, 3, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
